// File: rtl/product_pkg.sv
`default_nettype none
// ============================================================================
// Module   : product_pkg
// Purpose  : Shared types and constants for the product scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package product_pkg;

    // Scheduler phases: waiting for a request, multiplying, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    // Width of the optional completed-result counter.
    localparam int COUNT_W = 16;

    // Requester ID width: max(1, clog2(n)).
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/product_scheduler_shift_add_mul.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mul
// Purpose  : Iterative LSB-first shift-add unsigned multiplier. A start pulse
//            loads the operands; exactly WIDTH steps later done rises and the
//            product is held until the next start.
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int STEP_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] a_sh;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   b_sh;
    logic [STEP_W-1:0]  step;

    // Load on start, then one add/shift per cycle; the counter parks at WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            step <= STEP_W'(WIDTH);
        end else if (start) begin
            a_sh <= {{WIDTH{1'b0}}, a};
            b_sh <= b;
            acc  <= '0;
            step <= '0;
        end else if (!done) begin
            if (b_sh[0]) begin
                acc <= acc + a_sh;
            end
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            step <= step + 1'b1;
        end
    end

    assign done    = (step == STEP_W'(WIDTH));
    assign product = acc;

endmodule
`default_nettype wire

// File: rtl/product_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : product_scheduler
// Purpose  : Round-robin sharing of one shift-add multiplier between NUM_REQ
//            requesters; results return with the owner ID over valid/ready.
// Options  : PRODUCT_COUNT_EN adds a 16-bit wrapping count of result
//            handshakes on port prod_count.
// Revision : 1.0 - initial release
// ============================================================================
module product_scheduler
    import product_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]     req_a,
    input  logic [NUM_REQ*WIDTH-1:0]     req_b,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [2*WIDTH-1:0]           res_product,
    output logic [id_width(NUM_REQ)-1:0] res_id,
    output logic                         busy
`ifdef PRODUCT_COUNT_EN
    ,
    output logic [COUNT_W-1:0]           prod_count
`endif
);

    localparam int ID_W = id_width(NUM_REQ);

    sched_state_e        state;
    sched_state_e        next_state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     owner_id;
    logic [ID_W-1:0]     grant;
    logic                grant_found;
    logic                mul_start;
    logic                mul_done;
    logic [2*WIDTH-1:0]  mul_product;

    // Round-robin search: first asserted req_valid at or above rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant       = ID_W'(idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, grant strobe and multiplier start.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        mul_start  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant] = 1'b1;
                    mul_start        = 1'b1;
                    next_state       = BUSY;
                end
            end
            BUSY: begin
                if (mul_done) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Pointer advance on accept; result capture when the multiplier finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            owner_id    <= '0;
            res_product <= '0;
            res_id      <= '0;
        end else begin
            if (state == IDLE && grant_found) begin
                owner_id <= grant;
                rr_ptr   <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
            if (state == BUSY && mul_done) begin
                res_product <= mul_product;
                res_id      <= owner_id;
            end
        end
    end

    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

`ifdef PRODUCT_COUNT_EN
    // Count result handshakes, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_count <= '0;
        end else if (res_valid && res_ready) begin
            prod_count <= prod_count + 1'b1;
        end
    end
`endif

    shift_add_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (req_a[grant*WIDTH +: WIDTH]),
        .b       (req_b[grant*WIDTH +: WIDTH]),
        .done    (mul_done),
        .product (mul_product)
    );

endmodule
`default_nettype wire
